mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Converts a one-cycle load/store request from EX/MEM into a req/ack transaction on a variable-latency data memory.
- Returns load data as Memout_o, the memory-data input of MEM/WB.
- Drives stall_o, which freezes the PC, IF/ID, ID/EX, EX/MEM and MEM/WB (stall_i) while a transaction is outstanding.

Parameters:
TIMEOUT, 256, maximum WAIT cycles before the access is abandoned; 0 disables the timeout
ERR_DATA, 32'hDEADBEEF, value loaded into Memout_o when a load times out

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active low
MemRead_i  in  1  load request from EX/MEM
MemWrite_i  in  1  store request from EX/MEM
addr_i  in  32  byte address (ALU result) from EX/MEM
wdata_i  in  32  store data from EX/MEM
mem_req_o  out  1  request to data memory, registered
mem_we_o  out  1  1 = write, 0 = read; registered
mem_addr_o  out  32  word-aligned address, {addr_i[31:2],2'b00}; registered
mem_wdata_o  out  32  write data; registered
mem_ack_i  in  1  one-cycle completion strobe from memory
mem_rdata_i  in  32  read data, valid in the cycle mem_ack_i=1
Memout_o  out  32  load result to MEM/WB; registered
stall_o  out  1  pipeline freeze, combinational from state and inputs
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE; mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, Memout_o=0, err_o=0, wait counter=0.
- Reset asserted mid-WAIT drops mem_req_o immediately. The memory must tolerate the abandoned request; any later ack is ignored.
- States: IDLE, WAIT, DONE.
- IDLE, with MemRead_i|MemWrite_i:
  - stall_o=1.
  - Next edge: go to WAIT and latch mem_req_o=1, mem_we_o=MemWrite_i, mem_addr_o, mem_wdata_o=wdata_i; counter=0.
- IDLE, with no request: stall_o=0, stay in IDLE.
- MemRead_i=1 and MemWrite_i=1 together is illegal; the write takes priority (mem_we_o=1).
- WAIT:
  - stall_o=1; request outputs held stable.
  - mem_ack_i=1: mem_req_o<=0; if mem_we_o=0, Memout_o<=mem_rdata_i; go to DONE.
  - No ack: counter increments.
  - TIMEOUT≠0 and counter==TIMEOUT-1 without ack: mem_req_o<=0, err_o<=1; Memout_o<=ERR_DATA if read; go to DONE.
- DONE:
  - stall_o=0. The pipeline advances at this edge and MEM/WB captures Memout_o.
  - Next state is always IDLE. The request still held in EX/MEM this cycle is the completed one and is not re-issued.
- Latency:
  - Ack in the first WAIT cycle gives 3 cycles total (IDLE-stall, WAIT, DONE), i.e. 2 stall cycles.
  - Each extra ack-wait cycle adds 1 stall cycle.
  - Back-to-back memory instructions: the next one is evaluated in the IDLE cycle after DONE.
- Memout_o holds its value until the next load completion; stores do not change it.
- mem_ack_i outside WAIT is ignored.
- err_o is cleared only by reset.
- Non-memory instructions pass with zero stall.

Test Plan:
- Reset then idle, MemRead_i=MemWrite_i=0 for 10 cycles -> stall_o=0 throughout; mem_req_o=0, Memout_o=0, err_o=0.
- Load addr_i=0x0000_0104, memory acks 1 cycle after req with rdata=0x1234_5678:
  - stall_o=1 for exactly 2 cycles, then 0 for 1 cycle (DONE).
  - mem_addr_o=0x104, mem_we_o=0.
  - Memout_o=0x1234_5678 from the DONE cycle onward.
- Store addr_i=0x0000_0203, wdata_i=0xCAFE_F00D, ack after 4 wait cycles:
  - mem_addr_o=0x200, mem_we_o=1, mem_wdata_o=0xCAFE_F00D stable while req=1.
  - stall_o high 5 cycles.
  - Memout_o unchanged.
- Back-to-back: load (ack rdata=0x11) immediately followed by load (ack rdata=0x22) -> two distinct req pulses separated by the DONE cycle; no duplicate request; Memout_o 0x11 then 0x22.
- TIMEOUT=4, load with no ack:
  - mem_req_o drops after 4 WAIT cycles.
  - err_o=1, Memout_o=0xDEADBEEF.
  - Then IDLE; a subsequent normal load still completes and err_o stays 1.
- rst_i pulsed low during WAIT -> mem_req_o=0 and stall_o=0 immediately; a late mem_ack_i=1 after reset release is ignored (Memout_o stays 0).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns a one-cycle load/store from
// EX/MEM into a req/ack transaction and freezes the pipeline until it completes.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] Memout_o,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state;
  logic [31:0] wait_cnt;
  logic        req_any;
  logic        timed_out;

  assign req_any   = MemRead_i | MemWrite_i;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);

  // Gated by reset so an abandoned access releases the pipeline immediately.
  assign stall_o = rst_i && (((state == S_IDLE) && req_any) || (state == S_WAIT));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      Memout_o    <= '0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            state       <= S_WAIT;
            wait_cnt    <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;  // write wins if both are set
            mem_addr_o  <= {addr_i[31:2], 2'b00};
            mem_wdata_o <= wdata_i;
          end
        end
        S_WAIT: begin
          if (mem_ack_i) begin
            state     <= S_DONE;
            mem_req_o <= 1'b0;
            if (!mem_we_o) Memout_o <= mem_rdata_i;
          end else if (timed_out) begin
            state     <= S_DONE;
            mem_req_o <= 1'b0;
            err_o     <= 1'b1;
            if (!mem_we_o) Memout_o <= ERR_DATA;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        // EX/MEM still holds the finished instruction here; never re-issue it.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl (TIMEOUT=4) plus a
// hand-written reset-during-WAIT sequence.
module tb_mem_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] Memout_o;
  logic        stall_o, err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .Memout_o(Memout_o), .stall_o(stall_o), .err_o(err_o)
  );

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we;
    logic [31:0] maddr, mwdata, memout;
    logic        err;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs[NV];

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic ack, logic [31:0] rdata, logic stall, logic req,
                              logic we, logic [31:0] maddr, logic [31:0] mwdata,
                              logic [31:0] memout, logic err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.ack = ack; v.rdata = rdata;
    v.stall = stall; v.req = req; v.we = we; v.maddr = maddr; v.mwdata = mwdata;
    v.memout = memout; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ack, input logic [31:0] rdata);
    MemRead_i = rd; MemWrite_i = wr; addr_i = addr; wdata_i = wdata;
    mem_ack_i = ack; mem_rdata_i = rdata;
  endtask

  initial begin
    // Each row: inputs held for one cycle, outputs sampled at the falling edge.
    for (int i = 0; i < 10; i++)
      vecs[i] = mk(0,0,0,0,0,0, 0,0,0,0,0,0,0);
    // load 0x104, ack in first WAIT cycle
    vecs[10] = mk(1,0,32'h104,0,0,0,                  1,0,0,0,0,0,0);
    vecs[11] = mk(1,0,32'h104,0,1,32'h12345678,       1,1,0,32'h104,0,0,0);
    vecs[12] = mk(1,0,32'h104,0,0,0,                  0,0,0,32'h104,0,32'h12345678,0);
    // store 0x203, ack in 4th WAIT cycle (same cycle as timeout limit: ack wins)
    vecs[13] = mk(0,1,32'h203,32'hCAFEF00D,0,0,       1,0,0,32'h104,0,32'h12345678,0);
    for (int i = 14; i < 17; i++)
      vecs[i] = mk(0,1,32'h203,32'hCAFEF00D,0,0,      1,1,1,32'h200,32'hCAFEF00D,32'h12345678,0);
    vecs[17] = mk(0,1,32'h203,32'hCAFEF00D,1,32'h55555555, 1,1,1,32'h200,32'hCAFEF00D,32'h12345678,0);
    vecs[18] = mk(0,1,32'h203,32'hCAFEF00D,0,0,       0,0,1,32'h200,32'hCAFEF00D,32'h12345678,0);
    // back-to-back loads
    vecs[19] = mk(1,0,32'h10,0,0,0,                   1,0,1,32'h200,32'hCAFEF00D,32'h12345678,0);
    vecs[20] = mk(1,0,32'h10,0,1,32'h11,              1,1,0,32'h10,0,32'h12345678,0);
    vecs[21] = mk(1,0,32'h10,0,0,0,                   0,0,0,32'h10,0,32'h11,0);
    vecs[22] = mk(1,0,32'h14,0,0,0,                   1,0,0,32'h10,0,32'h11,0);
    vecs[23] = mk(1,0,32'h14,0,1,32'h22,              1,1,0,32'h14,0,32'h11,0);
    vecs[24] = mk(1,0,32'h14,0,0,0,                   0,0,0,32'h14,0,32'h22,0);
    // stray ack while idle is ignored
    vecs[25] = mk(0,0,0,0,1,32'h99,                   0,0,0,32'h14,0,32'h22,0);
    // load with no ack: times out after 4 WAIT cycles
    vecs[26] = mk(1,0,32'h21,0,0,0,                   1,0,0,32'h14,0,32'h22,0);
    for (int i = 27; i < 31; i++)
      vecs[i] = mk(1,0,32'h21,0,0,0,                  1,1,0,32'h20,0,32'h22,0);
    vecs[31] = mk(1,0,32'h21,0,0,0,                   0,0,0,32'h20,0,32'hDEADBEEF,1);
    // following load still works, err stays sticky
    vecs[32] = mk(1,0,32'h30,0,0,0,                   1,0,0,32'h20,0,32'hDEADBEEF,1);
    vecs[33] = mk(1,0,32'h30,0,1,32'hA5A5A5A5,        1,1,0,32'h30,0,32'hDEADBEEF,1);
    vecs[34] = mk(1,0,32'h30,0,0,0,                   0,0,0,32'h30,0,32'hA5A5A5A5,1);
    vecs[35] = mk(0,0,0,0,0,0,                        0,0,0,32'h30,0,32'hA5A5A5A5,1);

    rst_i = 1'b0;
    drive(0,0,0,0,0,0);
    repeat (2) @(negedge clk_i);
    chk("rst_req",    -1, {31'b0, mem_req_o}, 0);
    chk("rst_we",     -1, {31'b0, mem_we_o}, 0);
    chk("rst_addr",   -1, mem_addr_o, 0);
    chk("rst_wdata",  -1, mem_wdata_o, 0);
    chk("rst_memout", -1, Memout_o, 0);
    chk("rst_err",    -1, {31'b0, err_o}, 0);
    chk("rst_stall",  -1, {31'b0, stall_o}, 0);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk_i); #1;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].rdata);
      @(negedge clk_i);
      chk("stall",  i, {31'b0, stall_o},   {31'b0, vecs[i].stall});
      chk("req",    i, {31'b0, mem_req_o}, {31'b0, vecs[i].req});
      chk("we",     i, {31'b0, mem_we_o},  {31'b0, vecs[i].we});
      chk("addr",   i, mem_addr_o,         vecs[i].maddr);
      chk("wdata",  i, mem_wdata_o,        vecs[i].mwdata);
      chk("memout", i, Memout_o,           vecs[i].memout);
      chk("err",    i, {31'b0, err_o},     {31'b0, vecs[i].err});
    end

    // Reset pulsed mid-WAIT, then a late ack must be ignored.
    @(posedge clk_i); #1;
    drive(1,0,32'h40,0,0,0);
    @(posedge clk_i); #1;
    chk("rw_req_wait",   100, {31'b0, mem_req_o}, 1);
    chk("rw_stall_wait", 100, {31'b0, stall_o}, 1);
    #2;
    drive(0,0,0,0,0,0);
    rst_i = 1'b0;
    #1;
    chk("rw_req_rst",    101, {31'b0, mem_req_o}, 0);
    chk("rw_stall_rst",  101, {31'b0, stall_o}, 0);
    chk("rw_err_rst",    101, {31'b0, err_o}, 0);
    chk("rw_memout_rst", 101, Memout_o, 0);
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    drive(0,0,0,0,1,32'h77);
    @(negedge clk_i);
    chk("late_ack_stall", 102, {31'b0, stall_o}, 0);
    chk("late_ack_req",   102, {31'b0, mem_req_o}, 0);
    @(posedge clk_i); #1;
    drive(0,0,0,0,0,0);
    @(negedge clk_i);
    chk("late_ack_memout", 103, Memout_o, 0);
    chk("late_ack_req2",   103, {31'b0, mem_req_o}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
